reg_ctx_ctrl: RTL and testbench
===============================

Name: reg_ctx_ctrl

Overview:
Context save/restore sequencer for the 32x32 register file, used on OS context switches.
- On SAVE_REQ: reads registers FIRST_REG..LAST_REG through one register-file read port and writes each to a context area in data memory.
- On RESTORE_REQ: reads the context area and writes each word back through the register-file write port.
- Holds the CPU pipeline (CPU_STALL) while active.
- Sits between the core's register file, the data-memory port, and the context-switch trigger logic.

Parameters:
FIRST_REG, 1, first register index transferred (x0 skipped).
LAST_REG, 31, last register index transferred; FIRST_REG <= LAST_REG <= 31.
ADDR_STEP, 4, byte stride between consecutive register slots in memory.

Ports:
CLK  input  1  clock; all state changes on posedge.
RESET  input  1  synchronous, active-high reset.
SAVE_REQ  input  1  level; sampled only in IDLE.
RESTORE_REQ  input  1  level; sampled only in IDLE.
CTX_BASE  input  32  context area byte base address; latched at operation start.
CPU_STALL  output  1  high in every state except IDLE.
DONE  output  1  one-cycle pulse when an operation completes.
RF_RADDR  output  5  register-file read address.
RF_RDATA  input  32  register-file read data.
RF_WADDR  output  5  register-file write address.
RF_WDATA  output  32  register-file write data.
RF_WRITE  output  1  register-file write enable; write occurs at posedge.
MEM_ADDR  output  32  memory byte address.
MEM_WDATA  output  32  memory write data.
MEM_RDATA  input  32  memory read data; valid in the completion cycle.
MEM_READ  output  1  memory read request.
MEM_WRITE  output  1  memory write request.
MEM_BUSYWAIT  input  1  memory stall. A request completes at the posedge where it is asserted and MEM_BUSYWAIT=0.

Behaviour:
- Reset: state IDLE, idx=0, data register=0. All outputs 0 (CPU_STALL, DONE, RF_WRITE, MEM_READ, MEM_WRITE, all address/data buses).
- RESET has priority over everything, including mid-operation:
  - Outstanding memory request is dropped the next cycle.
  - No further register writes occur.
  - Registers/memory already transferred keep their values.
- States: IDLE, SAVE_RD, SAVE_WR, RST_RD, RST_WR, FIN.
- IDLE:
  - SAVE_REQ=1 -> SAVE_RD. RESTORE_REQ=1 (with SAVE_REQ=0) -> RST_RD.
  - Both high -> SAVE wins.
  - On start: latch base <= CTX_BASE, idx <= FIRST_REG.
  - Requests outside IDLE are ignored, not queued.
- SAVE_RD (1 cycle): RF_RADDR=idx. At posedge, data <= RF_RDATA. -> SAVE_WR.
- SAVE_WR:
  - Outputs: MEM_WRITE=1, MEM_ADDR=base+idx*ADDR_STEP (mod 2^32, wraps silently), MEM_WDATA=data.
  - Held stable while MEM_BUSYWAIT=1.
  - On completion: if idx==LAST_REG -> FIN; else idx++ -> SAVE_RD.
- RST_RD:
  - Outputs: MEM_READ=1, MEM_ADDR as above; held while MEM_BUSYWAIT=1.
  - On completion: data <= MEM_RDATA -> RST_WR.
- RST_WR (1 cycle): RF_WRITE=1, RF_WADDR=idx, RF_WDATA=data. Then: if idx==LAST_REG -> FIN; else idx++ -> RST_RD.
- FIN (1 cycle): DONE=1, CPU_STALL=1 -> IDLE.
- Output discipline:
  - MEM_READ and MEM_WRITE are never high together.
  - RF_WRITE is high only in RST_WR.
  - Outside its active state, each strobe is 0. RF_RADDR/RF_WADDR/MEM_ADDR hold their last value.
- Latency with zero wait states, from the request-sampling posedge:
  - 2 cycles per register, plus 1 FIN cycle.
  - CPU_STALL high for 2*(LAST_REG-FIRST_REG+1)+1 = 63 cycles at defaults.
  - Each busywait cycle adds 1.
- A request held high through FIN starts a new operation only after one IDLE cycle; there is no back-to-back start from FIN.

Test Plan:
1. Preload x1..x31 = 0x1000_0000+n. CTX_BASE=0x200, SAVE_REQ pulse, BUSYWAIT=0 -> 31 writes, mem[0x200+4n]=0x1000_0000+n. CPU_STALL high exactly 63 cycles. DONE one pulse in cycle 63. No RF_WRITE.
2. Same save with MEM_BUSYWAIT=1 for 2 cycles on every access -> MEM_ADDR/MEM_WDATA stable during stalls. CPU_STALL high 125 cycles. Memory contents identical to test 1.
3. Memory slots 0x400+4n = ~n. RESTORE_REQ, CTX_BASE=0x400 -> RF_WRITE pulses for x1..x31 in order, xn = ~n. x0 untouched. DONE after 63 cycles.
4. SAVE_REQ and RESTORE_REQ high in the same IDLE cycle -> only MEM_WRITE activity, no MEM_READ. RESTORE_REQ re-pulsed mid-save -> ignored.
5. RESET asserted in the cycle of the 10th SAVE_WR -> next cycle: IDLE, all outputs 0, no DONE. Mem slots 1..9 written; slots 10..31 unchanged.
6. CTX_BASE=0xFFFF_FFF0, save -> addresses wrap (idx=4 -> 0x0000_0000) without error.

Source files
------------

// File: rtl/reg_ctx_ctrl.sv
// Context save/restore sequencer: walks registers FIRST_REG..LAST_REG between the
// register file and a memory context area, stalling the CPU while it runs.
module reg_ctx_ctrl #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31,
    parameter int ADDR_STEP = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SAVE_REQ,
    input  logic        RESTORE_REQ,
    input  logic [31:0] CTX_BASE,
    output logic        CPU_STALL,
    output logic        DONE,
    output logic [4:0]  RF_RADDR,
    input  logic [31:0] RF_RDATA,
    output logic [4:0]  RF_WADDR,
    output logic [31:0] RF_WDATA,
    output logic        RF_WRITE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    input  logic        MEM_BUSYWAIT
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE_RD = 3'd1,
        SAVE_WR = 3'd2,
        RST_RD  = 3'd3,
        RST_WR  = 3'd4,
        FIN     = 3'd5
    } state_t;

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    state_t      state_reg;
    logic [4:0]  idx_reg;
    logic [31:0] base_reg;
    logic [31:0] data_reg;
    logic        stall_reg;
    logic        done_reg;
    logic [4:0]  raddr_reg;
    logic [4:0]  waddr_reg;
    logic        rf_write_reg;
    logic [31:0] mem_addr_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;

    // Slot address wraps modulo 2^32 by construction of the 32-bit sum.
    function automatic logic [31:0] slot_addr(input logic [31:0] base, input logic [4:0] idx);
        return base + 32'(idx) * 32'(ADDR_STEP);
    endfunction

    // Every output is a register, loaded on the transition into the state that drives it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            base_reg      <= '0;
            data_reg      <= '0;
            stall_reg     <= 1'b0;
            done_reg      <= 1'b0;
            raddr_reg     <= '0;
            waddr_reg     <= '0;
            rf_write_reg  <= 1'b0;
            mem_addr_reg  <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (SAVE_REQ) begin
                        state_reg <= SAVE_RD;
                        base_reg  <= CTX_BASE;
                        idx_reg   <= FIRST_IDX;
                        raddr_reg <= FIRST_IDX;
                        stall_reg <= 1'b1;
                    end else if (RESTORE_REQ) begin
                        state_reg    <= RST_RD;
                        base_reg     <= CTX_BASE;
                        idx_reg      <= FIRST_IDX;
                        mem_addr_reg <= slot_addr(CTX_BASE, FIRST_IDX);
                        mem_read_reg <= 1'b1;
                        stall_reg    <= 1'b1;
                    end
                end
                SAVE_RD: begin
                    state_reg     <= SAVE_WR;
                    data_reg      <= RF_RDATA;
                    mem_addr_reg  <= slot_addr(base_reg, idx_reg);
                    mem_write_reg <= 1'b1;
                end
                SAVE_WR: begin
                    if (!MEM_BUSYWAIT) begin
                        mem_write_reg <= 1'b0;
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= FIN;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= SAVE_RD;
                            idx_reg   <= idx_reg + 5'd1;
                            raddr_reg <= idx_reg + 5'd1;
                        end
                    end
                end
                RST_RD: begin
                    if (!MEM_BUSYWAIT) begin
                        state_reg    <= RST_WR;
                        data_reg     <= MEM_RDATA;
                        mem_read_reg <= 1'b0;
                        rf_write_reg <= 1'b1;
                        waddr_reg    <= idx_reg;
                    end
                end
                RST_WR: begin
                    rf_write_reg <= 1'b0;
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= FIN;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg    <= RST_RD;
                        idx_reg      <= idx_reg + 5'd1;
                        mem_addr_reg <= slot_addr(base_reg, idx_reg + 5'd1);
                        mem_read_reg <= 1'b1;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    stall_reg <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign CPU_STALL = stall_reg;
    assign DONE      = done_reg;
    assign RF_RADDR  = raddr_reg;
    assign RF_WADDR  = waddr_reg;
    assign RF_WDATA  = data_reg;
    assign RF_WRITE  = rf_write_reg;
    assign MEM_ADDR  = mem_addr_reg;
    assign MEM_WDATA = data_reg;
    assign MEM_READ  = mem_read_reg;
    assign MEM_WRITE = mem_write_reg;

endmodule

// File: tb/tb_reg_ctx_ctrl.sv
// Scoreboard bench for reg_ctx_ctrl: stimulus queues expected memory/register-file
// writes, a negedge monitor models memory + busywait and checks each transaction.
module tb_reg_ctx_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        SAVE_REQ = 1'b0;
    logic        RESTORE_REQ = 1'b0;
    logic [31:0] CTX_BASE = '0;
    logic        CPU_STALL, DONE, RF_WRITE, MEM_READ, MEM_WRITE;
    logic [4:0]  RF_RADDR, RF_WADDR;
    logic [31:0] RF_RDATA, RF_WDATA, MEM_ADDR, MEM_WDATA;
    logic [31:0] MEM_RDATA = '0;
    logic        MEM_BUSYWAIT = 1'b0;

    reg_ctx_ctrl dut (
        .CLK(CLK), .RESET(RESET), .SAVE_REQ(SAVE_REQ), .RESTORE_REQ(RESTORE_REQ),
        .CTX_BASE(CTX_BASE), .CPU_STALL(CPU_STALL), .DONE(DONE),
        .RF_RADDR(RF_RADDR), .RF_RDATA(RF_RDATA), .RF_WADDR(RF_WADDR),
        .RF_WDATA(RF_WDATA), .RF_WRITE(RF_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;

    txn_t        exp_mem[$];
    txn_t        exp_rf[$];
    logic [31:0] rf [32];
    logic [31:0] mem [logic [31:0]];
    int          n_checks = 0;
    int          n_fail = 0;
    int          ws = 0;
    int          bw_cnt = 0;
    int          stall_cnt = 0;
    int          last_stall = 0;
    int          done_cnt = 0;
    int          mem_rd_cnt = 0;
    int          rf_wr_cnt = 0;
    logic        prev_bw = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;

    assign RF_RDATA = rf[RF_RADDR];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Memory model with programmable wait states, plus the scoreboard monitor.
    always @(negedge CLK) begin
        txn_t e;
        logic req;
        req = (MEM_READ === 1'b1) || (MEM_WRITE === 1'b1);
        if (req && bw_cnt < ws) begin
            MEM_BUSYWAIT = 1'b1;
            bw_cnt++;
        end else begin
            MEM_BUSYWAIT = 1'b0;
        end
        MEM_RDATA = mem_rd(MEM_ADDR);
        if (MEM_READ === 1'b1 && MEM_WRITE === 1'b1) chk("rd_wr_exclusive", 32'd1, 32'd0);
        if (prev_bw && req) begin
            chk("addr_stable", MEM_ADDR, prev_addr);
            if (MEM_WRITE === 1'b1) chk("wdata_stable", MEM_WDATA, prev_wdata);
        end
        prev_bw = MEM_BUSYWAIT;
        prev_addr = MEM_ADDR;
        prev_wdata = MEM_WDATA;
        if (req && !MEM_BUSYWAIT && !RESET) begin
            bw_cnt = 0;
            if (MEM_READ === 1'b1) mem_rd_cnt++;
            if (MEM_WRITE === 1'b1) begin
                $display("mem write addr=%h data=%h", MEM_ADDR, MEM_WDATA);
                if (exp_mem.size() == 0) begin
                    chk("unexpected_mem_write", MEM_ADDR, 32'hxxxx_xxxx);
                end else begin
                    e = exp_mem.pop_front();
                    chk("mem_addr", MEM_ADDR, e.a);
                    chk("mem_wdata", MEM_WDATA, e.d);
                end
                mem[MEM_ADDR] = MEM_WDATA;
            end
        end
        if (!req) bw_cnt = 0;
        if (RF_WRITE === 1'b1 && !RESET) begin
            rf_wr_cnt++;
            $display("rf write x%0d data=%h", RF_WADDR, RF_WDATA);
            if (exp_rf.size() == 0) begin
                chk("unexpected_rf_write", {27'd0, RF_WADDR}, 32'hxxxx_xxxx);
            end else begin
                e = exp_rf.pop_front();
                chk("rf_waddr", {27'd0, RF_WADDR}, e.a);
                chk("rf_wdata", RF_WDATA, e.d);
            end
            rf[RF_WADDR] = RF_WDATA;
        end
        if (CPU_STALL === 1'b1) stall_cnt++;
        else stall_cnt = 0;
        if (DONE === 1'b1) begin
            last_stall = stall_cnt;
            done_cnt++;
            $display("done after %0d stall cycles", stall_cnt);
        end
    end

    task automatic push_save(input logic [31:0] base, input int first, input int last);
        for (int n = first; n <= last; n++)
            exp_mem.push_back('{a: base + 32'(n) * 32'd4, d: rf[n]});
    endtask

    task automatic start_op(input logic s, input logic r, input logic [31:0] base);
        @(posedge CLK); #1;
        SAVE_REQ = s; RESTORE_REQ = r; CTX_BASE = base;
        @(posedge CLK); #1;
        SAVE_REQ = 0; RESTORE_REQ = 0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (done_cnt != d0) break;
            @(posedge CLK); #1;
        end
        if (k == budget) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_op(input string tag, input int d0, input int stall_exp);
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(last_stall), 32'(stall_exp));
        chk({tag, "_mem_queue_left"}, 32'(exp_mem.size()), 32'd0);
        chk({tag, "_rf_queue_left"}, 32'(exp_rf.size()), 32'd0);
        @(posedge CLK); #1;
        chk({tag, "_stall_released"}, {31'd0, CPU_STALL}, 32'd0);
    endtask

    initial begin
        int d0, rd0, rw0;
        for (int n = 0; n < 32; n++) rf[n] = 32'h1000_0000 + 32'(n);
        rf[0] = 32'h5A5A_5A5A;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_stall", {31'd0, CPU_STALL}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_strobes", {29'd0, RF_WRITE, MEM_READ, MEM_WRITE}, 32'd0);
        chk("rst_mem_addr", MEM_ADDR, 32'd0);
        chk("rst_mem_wdata", MEM_WDATA, 32'd0);
        chk("rst_rf_addrs", {22'd0, RF_RADDR, RF_WADDR}, 32'd0);
        RESET = 0;

        // 1: zero-wait save
        d0 = done_cnt; rw0 = rf_wr_cnt;
        push_save(32'h200, 1, 31);
        start_op(1, 0, 32'h200);
        wait_done(d0, 500);
        finish_op("t1", d0, 63);
        chk("t1_no_rf_write", 32'(rf_wr_cnt - rw0), 32'd0);
        for (int n = 1; n <= 31; n++) chk("t1_mem_slot", mem_rd(32'h200 + 32'(n) * 4), 32'h1000_0000 + 32'(n));

        // 2: same save with two wait states per access
        for (int n = 1; n <= 31; n++) mem[32'h200 + 32'(n) * 4] = 32'h0;
        ws = 2; d0 = done_cnt;
        push_save(32'h200, 1, 31);
        start_op(1, 0, 32'h200);
        wait_done(d0, 500);
        finish_op("t2", d0, 125);
        ws = 0;
        for (int n = 1; n <= 31; n++) chk("t2_mem_slot", mem_rd(32'h200 + 32'(n) * 4), 32'h1000_0000 + 32'(n));

        // 3: restore ~n from 0x400
        for (int n = 1; n <= 31; n++) begin
            mem[32'h400 + 32'(n) * 4] = ~32'(n);
            exp_rf.push_back('{a: 32'(n), d: ~32'(n)});
        end
        d0 = done_cnt;
        start_op(0, 1, 32'h400);
        wait_done(d0, 500);
        finish_op("t3", d0, 63);
        chk("t3_x0_untouched", rf[0], 32'h5A5A_5A5A);
        chk("t3_x31", rf[31], ~32'd31);

        // 4: simultaneous requests, then a restore request mid-save
        d0 = done_cnt; rd0 = mem_rd_cnt;
        push_save(32'h600, 1, 31);
        start_op(1, 1, 32'h600);
        repeat (10) @(posedge CLK);
        #1 RESTORE_REQ = 1;
        repeat (3) @(posedge CLK);
        #1 RESTORE_REQ = 0;
        wait_done(d0, 500);
        finish_op("t4", d0, 63);
        repeat (3) @(posedge CLK);
        #1;
        chk("t4_no_mem_read", 32'(mem_rd_cnt - rd0), 32'd0);
        chk("t4_not_queued", {31'd0, CPU_STALL}, 32'd0);

        // 5: reset during the 10th save write
        for (int n = 1; n <= 31; n++) mem[32'h800 + 32'(n) * 4] = 32'hAAAA_0000 + 32'(n);
        d0 = done_cnt;
        push_save(32'h800, 1, 9);
        start_op(1, 0, 32'h800);
        for (int k = 0; k < 200; k++) begin
            if (MEM_WRITE === 1'b1 && MEM_ADDR == 32'h800 + 32'd40) break;
            @(posedge CLK); #1;
        end
        chk("t5_reached_slot10", MEM_ADDR, 32'h828);
        RESET = 1;
        @(posedge CLK); #1;
        chk("t5_stall", {31'd0, CPU_STALL}, 32'd0);
        chk("t5_strobes", {28'd0, DONE, RF_WRITE, MEM_READ, MEM_WRITE}, 32'd0);
        chk("t5_mem_addr", MEM_ADDR, 32'd0);
        RESET = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t5_mem_queue_left", 32'(exp_mem.size()), 32'd0);
        for (int n = 1; n <= 9; n++) chk("t5_written", mem_rd(32'h800 + 32'(n) * 4), rf[n]);
        for (int n = 10; n <= 31; n++) chk("t5_unchanged", mem_rd(32'h800 + 32'(n) * 4), 32'hAAAA_0000 + 32'(n));

        // 6: address wrap past 2^32
        d0 = done_cnt;
        push_save(32'hFFFF_FFF0, 1, 31);
        start_op(1, 0, 32'hFFFF_FFF0);
        wait_done(d0, 500);
        finish_op("t6", d0, 63);
        chk("t6_wrapped_slot4", mem_rd(32'h0), rf[4]);
        chk("t6_slot3", mem_rd(32'hFFFF_FFFC), rf[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
